// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter, dmem_arb_pick).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two memory requesters.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic last_i,
    output logic valid_o,
    output logic win_o
);

`ifndef DMEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the last-grant pointer.
    logic last_unused;
    assign last_unused = last_i;
`endif

    always_comb begin
        valid_o = p0_req_i | p1_req_i;
        win_o   = PORT_CPU;
        if (p0_req_i && p1_req_i) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            win_o = ~last_i;
`else
            win_o = PORT_CPU;
`endif
        end else if (p1_req_i) begin
            win_o = PORT_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data memory.
// Build option: DMEM_ARB_ROUND_ROBIN_EN (round-robin tie-break; default fixed priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writeData,
    output logic          mem_memwrite,
    output logic          mem_memread,
    input  logic [DW-1:0] mem_readdata,
    output logic          busy
);

    localparam int CW = 2;

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("dmem_arbiter: RD_LAT must be in 1..3");
        end
    endgenerate

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_q, win_d;
    logic          ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          pick_valid;
    logic          pick_win;

    dmem_arb_pick u_pick (
        .p0_req_i (p0_req),
        .p1_req_i (p1_req),
        .last_i   (ptr_q),
        .valid_o  (pick_valid),
        .win_o    (pick_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= PORT_CPU;
            ptr_q    <= PORT_DMA;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        ptr_d        = ptr_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
        p0_ack       = 1'b0;
        p1_ack       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_win;
                    ptr_d   = pick_win;
                    we_d    = (pick_win == PORT_DMA) ? p1_we    : p0_we;
                    addr_d  = (pick_win == PORT_DMA) ? p1_addr  : p0_addr;
                    wdata_d = (pick_win == PORT_DMA) ? p1_wdata : p0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    mem_memwrite = 1'b1;
                    state_d      = ACK;
                end else begin
                    mem_memread = 1'b1;
                    if (RD_LAT == 1) begin
                        if (win_q == PORT_DMA) rdata1_d = mem_readdata;
                        else                   rdata0_d = mem_readdata;
                        state_d = ACK;
                    end else begin
                        // cnt counts the remaining WAIT cycles after the current one.
                        cnt_d   = CW'(RD_LAT - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_memread = 1'b1;
                if (cnt_q == '0) begin
                    if (win_q == PORT_DMA) rdata1_d = mem_readdata;
                    else                   rdata0_d = mem_readdata;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                p0_ack  = (win_q == PORT_CPU);
                p1_ack  = (win_q == PORT_DMA);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;
    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with a behavioural memory and scoreboard.
module tb_dmem_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic          p0_we = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writeData;
    logic          mem_memwrite, mem_memread;
    logic [DW-1:0] mem_readdata;
    logic          busy;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;

    // memory behind the arbiter
    logic [DW-1:0] ram [256];

    // reference model and scoreboard
    logic [DW-1:0] ref_mem [256];
    bit            ref_written [256];
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    logic          pend_v [2];
    logic          pend_we [2];
    logic [AW-1:0] pend_a [2];
    logic [DW-1:0] pend_d [2];

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p0_req        (p0_req),
        .p0_we         (p0_we),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_ack        (p0_ack),
        .p0_rdata      (p0_rdata),
        .p1_req        (p1_req),
        .p1_we         (p1_we),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_ack        (p1_ack),
        .p1_rdata      (p1_rdata),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_readdata  (mem_readdata),
        .busy          (busy)
    );

    // clock / reset-independent infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(posedge clk) if (mem_memwrite) ram[mem_address] <= mem_writeData;
    assign mem_readdata = ram[mem_address];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
        end
        pend_v[p] = r; pend_we[p] = w; pend_a[p] = a; pend_d[p] = d;
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    // Issue one access from port p (called at posedge+1), wait for its ack, release at the ack edge.
    task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat, output int at);
        logic [DW:0] e;
        int c;
        e = w ? {1'b0, {DW{1'b0}}} : {1'b1, ref_mem[a]};
        if (w) begin
            ref_mem[a] = d;
            ref_written[a] = 1'b1;
        end
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        set_port(p, 1'b1, w, a, d);
        c = 0; lat = -1; at = -1;
        while (lat < 0 && c < 3000) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (ack_of(p)) begin
                lat = c;
                at = cyc_cnt;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL ack_timeout_p%0d: got no ack want ack", p);
        end
        @(posedge clk);
        #1;
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [AW-1:0] a;
        logic w;
        int l, t, gap;
        for (int i = 0; i < n; i++) begin
            a = (p == 0) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(128, 255));
            w = ($urandom_range(0, 1) == 1) || !ref_written[a];
            drive(p, w, a, $urandom, l, t);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // monitor: pops the scoreboard on each ack and polices the memory strobes
    initial begin
        logic [DW-1:0] prev0, prev1;
        logic [DW:0]   e;
        int            rd_run, wr_run;
        logic          m, rd_ack0, rd_ack1;
        prev0 = '0; prev1 = '0; rd_run = 0; wr_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev0 = '0; prev1 = '0; rd_run = 0; wr_run = 0;
            end else begin
                if (mem_memwrite) begin
                    wr_run++;
                    check("wr_excludes_rd", mem_memread, 1'b0);
                    m = 1'b0;
                    for (int k = 0; k < 2; k++)
                        if (pend_v[k] && pend_we[k] && pend_a[k] == mem_address && pend_d[k] == mem_writeData) m = 1'b1;
                    check("wr_strobe_fields", m, 1'b1);
                end else if (wr_run > 0) begin
                    check("wr_strobe_len", wr_run, 1);
                    wr_run = 0;
                end
                if (mem_memread) begin
                    rd_run++;
                    m = 1'b0;
                    for (int k = 0; k < 2; k++)
                        if (pend_v[k] && !pend_we[k] && pend_a[k] == mem_address) m = 1'b1;
                    check("rd_strobe_addr", m, 1'b1);
                end else if (rd_run > 0) begin
                    check("rd_strobe_len", rd_run, RD_LAT);
                    rd_run = 0;
                end
                rd_ack0 = 1'b0;
                rd_ack1 = 1'b0;
                if (p0_ack) begin
                    check("p0_ack_expected", exp_q0.size() != 0, 1'b1);
                    check("single_ack", p1_ack, 1'b0);
                    if (exp_q0.size() != 0) begin
                        e = exp_q0.pop_front();
                        rd_ack0 = e[DW];
                        if (e[DW]) check("p0_rdata", p0_rdata, e[DW-1:0]);
                    end
                end
                if (p1_ack) begin
                    check("p1_ack_expected", exp_q1.size() != 0, 1'b1);
                    if (exp_q1.size() != 0) begin
                        e = exp_q1.pop_front();
                        rd_ack1 = e[DW];
                        if (e[DW]) check("p1_rdata", p1_rdata, e[DW-1:0]);
                    end
                end
                if (!rd_ack0) check("p0_rdata_hold", p0_rdata, prev0);
                if (!rd_ack1) check("p1_rdata_hold", p1_rdata, prev1);
                prev0 = p0_rdata;
                prev1 = p1_rdata;
            end
        end
    end

    // main sequence
    initial begin
        int lat0, at0, lat1, at1, ls, as, p0_last;
        for (int k = 0; k < 2; k++) begin
            pend_v[k] = 1'b0; pend_we[k] = 1'b0; pend_a[k] = '0; pend_d[k] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {p0_ack, p1_ack}, 2'b00);
        check("rst_strobes", {mem_memwrite, mem_memread}, 2'b00);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writeData", mem_writeData, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-port write then read back
        drive(0, 1'b1, 8'd12, 32'd2, lat0, at0);
        check("p0_wr_lat", lat0, 2);
        drive(0, 1'b0, 8'd12, '0, lat0, at0);
        check("p0_rd_lat", lat0, RD_LAT + 1);
        check("p0_rd_value", p0_rdata, 32'd2);

        // simultaneous writes: pointer starts at port 1, so port 0 goes first
        fork
            drive(0, 1'b1, 8'd12, 32'd2, lat0, at0);
            drive(1, 1'b1, 8'd10, 32'd24, lat1, at1);
        join
        check("tie_wr_p0_lat", lat0, 2);
        check("tie_wr_p1_lat", lat1, 5);

        // simultaneous reads after port 1 was granted last
        fork
            drive(0, 1'b0, 8'd12, '0, lat0, at0);
            drive(1, 1'b0, 8'd10, '0, lat1, at1);
        join
        check("tie_rd_p0_lat", lat0, RD_LAT + 1);
        check("tie_rd_p1_lat", lat1, 2 * RD_LAT + 3);
        check("tie_rd_p0_val", p0_rdata, 32'd2);
        check("tie_rd_p1_val", p1_rdata, 32'd24);

        // tie after port 0 was granted last separates the two arbitration modes
        drive(0, 1'b1, 8'd40, 32'h55, lat0, at0);
        fork
            drive(0, 1'b0, 8'd12, '0, lat0, at0);
            drive(1, 1'b0, 8'd10, '0, lat1, at1);
        join
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        check("rr_tie_p1_lat", lat1, RD_LAT + 1);
        check("rr_tie_p0_lat", lat0, 2 * RD_LAT + 3);
`else
        check("fix_tie_p0_lat", lat0, RD_LAT + 1);
        check("fix_tie_p1_lat", lat1, 2 * RD_LAT + 3);
`endif

        // port 0 requests back to back while port 1 waits
        p0_last = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    drive(0, (i % 2) == 0, AW'(30 + i / 2), $urandom, ls, as);
                    p0_last = as;
                end
            end
            drive(1, 1'b0, 8'd10, '0, lat1, at1);
        join
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        check("rr_p1_served_first", lat1, RD_LAT + 1);
        check("rr_p1_before_p0_end", at1 < p0_last, 1'b1);
`else
        check("fix_p1_after_p0", at1, p0_last + RD_LAT + 2);
`endif
        check("p1_rd_val", p1_rdata, 32'd24);

        // reset in the middle of a read wait
        set_port(1, 1'b1, 1'b0, 8'd12, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_memread", mem_memread, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {mem_memwrite, mem_memread}, 2'b00);
        check("mid_rst_acks", {p0_ack, p1_ack}, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("mid_rst_address", mem_address, 0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_acks", {p0_ack, p1_ack}, 2'b00);
        @(posedge clk);
        #1;

        // random traffic on disjoint address halves
        fork
            rand_port(0, 25);
            rand_port(1, 25);
        join

        repeat (5) @(negedge clk);
        check("p0_queue_drained", exp_q0.size(), 0);
        check("p1_queue_drained", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
